// File: rtl/hazard_stall_ctrl.sv
// Stall scheduler for the 5-stage MIPS pipeline: data-hazard and mult/div stalls.
// Optional STALL_STATS_EN macro adds a saturating stall_cycles counter port.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      FD_IR,
   input  logic [31:0]      DE_IR,
   input  logic [31:0]      EM_IR,
   output logic             stall,
   output logic             md_busy,
   output logic [CNT_W-1:0] md_cnt
`ifdef STALL_STATS_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_ORI = 6'h0d;
   localparam logic [5:0] OP_LUI = 6'h0f;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_JAL = 6'h03;

   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_JR    = 6'h08;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   // Tuse of 3 means "not read": it can never be below any Tnew (max 2).
   localparam logic [1:0] T_NONE = 2'd3;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic is_rfn(input logic [31:0] ir,
                                   input logic [5:0]  fn);
      is_rfn = (ir[31:26] == OP_R) && (ir[5:0] == fn);
   endfunction

   function automatic logic is_mul(input logic [31:0] ir);
      is_mul = is_rfn(ir, F_MULT) || is_rfn(ir, F_MULTU);
   endfunction

   function automatic logic is_div(input logic [31:0] ir);
      is_div = is_rfn(ir, F_DIV) || is_rfn(ir, F_DIVU);
   endfunction

   function automatic logic is_md(input logic [31:0] ir);
      is_md = is_mul(ir) || is_div(ir)
           || is_rfn(ir, F_MFHI) || is_rfn(ir, F_MFLO)
           || is_rfn(ir, F_MTHI) || is_rfn(ir, F_MTLO);
   endfunction

   function automatic logic is_alu(input logic [31:0] ir);
      is_alu = is_rfn(ir, F_ADDU) || is_rfn(ir, F_SUBU)
            || is_rfn(ir, F_SLL)  || is_rfn(ir, F_MFHI)
            || is_rfn(ir, F_MFLO) || (ir[31:26] == OP_ORI)
            || (ir[31:26] == OP_LUI);
   endfunction

   function automatic logic [1:0] tuse_rs(input logic [31:0] ir);
      tuse_rs = T_NONE;
      if (is_rfn(ir, F_JR) || ir[31:26] == OP_BEQ)
         tuse_rs = 2'd0;
      else if (is_rfn(ir, F_ADDU) || is_rfn(ir, F_SUBU)
            || is_mul(ir) || is_div(ir)
            || is_rfn(ir, F_MTHI) || is_rfn(ir, F_MTLO)
            || ir[31:26] == OP_ORI || ir[31:26] == OP_LW
            || ir[31:26] == OP_SW)
         tuse_rs = 2'd1;
   endfunction

   function automatic logic [1:0] tuse_rt(input logic [31:0] ir);
      tuse_rt = T_NONE;
      if (ir[31:26] == OP_BEQ)
         tuse_rt = 2'd0;
      else if (ir[31:26] == OP_SW)
         tuse_rt = 2'd2;
      else if (is_rfn(ir, F_ADDU) || is_rfn(ir, F_SUBU)
            || is_rfn(ir, F_SLL) || is_mul(ir) || is_div(ir))
         tuse_rt = 2'd1;
   endfunction

   // Destination register; $0 doubles as "writes nothing".
   function automatic logic [4:0] wreg(input logic [31:0] ir);
      wreg = 5'd0;
      if (is_rfn(ir, F_ADDU) || is_rfn(ir, F_SUBU) || is_rfn(ir, F_SLL)
       || is_rfn(ir, F_MFHI) || is_rfn(ir, F_MFLO))
         wreg = ir[15:11];
      else if (ir[31:26] == OP_ORI || ir[31:26] == OP_LUI
            || ir[31:26] == OP_LW)
         wreg = ir[20:16];
      else if (ir[31:26] == OP_JAL)
         wreg = 5'd31;
   endfunction

   function automatic logic [1:0] tnew_de(input logic [31:0] ir);
      tnew_de = 2'd0;
      if (ir[31:26] == OP_LW)
         tnew_de = 2'd2;
      else if (is_alu(ir))
         tnew_de = 2'd1;
   endfunction

   function automatic logic [1:0] tnew_em(input logic [31:0] ir);
      tnew_em = (ir[31:26] == OP_LW) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic hit(input logic [4:0] src,
                                input logic [1:0] tuse,
                                input logic [4:0] wr,
                                input logic [1:0] tnew);
      hit = (src != 5'd0) && (src == wr) && (tuse < tnew);
   endfunction

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start;
   logic             data_stall;
   logic             md_stall;
   logic [4:0]       fd_rs, fd_rt, de_wr, em_wr;
   logic [1:0]       use_rs, use_rt, new_de, new_em;

   assign fd_rs  = FD_IR[25:21];
   assign fd_rt  = FD_IR[20:16];
   assign use_rs = tuse_rs(FD_IR);
   assign use_rt = tuse_rt(FD_IR);
   assign de_wr  = wreg(DE_IR);
   assign em_wr  = wreg(EM_IR);
   assign new_de = tnew_de(DE_IR);
   assign new_em = tnew_em(EM_IR);

   // Per source, per stage hazard terms ORed into one data stall.
   always_comb begin
      data_stall = hit(fd_rs, use_rs, de_wr, new_de)
                || hit(fd_rt, use_rt, de_wr, new_de)
                || hit(fd_rs, use_rs, em_wr, new_em)
                || hit(fd_rt, use_rt, em_wr, new_em);
   end

   assign start    = (state_q == S_IDLE) && (is_mul(DE_IR) || is_div(DE_IR));
   assign md_busy  = (state_q == S_BUSY);
   assign md_cnt   = cnt_q;
   assign md_stall = is_md(FD_IR) && (start || md_busy);
   assign stall    = data_stall || md_stall;

   // md unit next state: load on start, count down while busy.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_BUSY;
               cnt_d   = is_mul(DE_IR) ? MULT_LD : DIV_LD;
            end
         end
         S_BUSY: begin
            if (cnt_q == CNT_ONE) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // md unit state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef STALL_STATS_EN
   logic [31:0] stall_cycles_q;

   // Saturating count of cycles spent stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cycles_q <= '0;
      else if (stall && stall_cycles_q != 32'hFFFF_FFFF)
         stall_cycles_q <= stall_cycles_q + 32'd1;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed IR vectors, negedge monitor.
// STALL_STATS_EN, when defined, also checks the stall_cycles counter.
module tb_hazard_stall_ctrl;

   localparam logic [31:0] LW1    = 32'h8c010000;
   localparam logic [31:0] LW0    = 32'h8c000000;
   localparam logic [31:0] ADDU_R = 32'h00221021;
   localparam logic [31:0] ADDU1  = 32'h00430821;
   localparam logic [31:0] SW1    = 32'hac010000;
   localparam logic [31:0] SW_RS1 = 32'hac200000;
   localparam logic [31:0] BEQ_A  = 32'h1022fff5;
   localparam logic [31:0] BEQ_B  = 32'h1022ffea;
   localparam logic [31:0] JAL    = 32'h0c000000;
   localparam logic [31:0] JR31   = 32'h03e00008;
   localparam logic [31:0] MULT   = 32'h00220018;
   localparam logic [31:0] DIV    = 32'h0022001a;
   localparam logic [31:0] MFHI   = 32'h00001010;
   localparam logic [31:0] MFLO   = 32'h00000012;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] FD_IR, DE_IR, EM_IR;
   logic        stall, md_busy;
   logic [7:0]  md_cnt;
`ifdef STALL_STATS_EN
   logic [31:0] stall_cycles;
`endif

   typedef struct {
      string       name;
      logic        st;
      logic        bz;
      logic [7:0]  cnt;
      bit          chk_sc;
      logic [31:0] sc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   hazard_stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .FD_IR   (FD_IR),
      .DE_IR   (DE_IR),
      .EM_IR   (EM_IR),
      .stall   (stall),
      .md_busy (md_busy),
      .md_cnt  (md_cnt)
`ifdef STALL_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit is_muldiv(input logic [31:0] ir);
      is_muldiv = (ir[31:26] == 6'h00) && (ir[5:2] == 4'b0110);
   endfunction

   task automatic push(input string nm, input logic es, input logic eb,
                       input logic [7:0] ec, input bit csc,
                       input logic [31:0] esc);
      exp_t e;
      e.name   = nm;
      e.st     = es;
      e.bz     = eb;
      e.cnt    = ec;
      e.chk_sc = csc;
      e.sc     = esc;
      q.push_back(e);
   endtask

   task automatic step(input string nm, input logic r,
                       input logic [31:0] fd, input logic [31:0] de,
                       input logic [31:0] em, input logic es,
                       input logic eb, input logic [7:0] ec,
                       input bit csc = 1'b0, input logic [31:0] esc = 32'd0);
      reset = r;
      FD_IR = fd;
      DE_IR = de;
      EM_IR = em;
      push(nm, es, eb, ec, csc, esc);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expectation per cycle, compared away from the clock edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (stall !== e.st) begin
            errors++;
            $display("FAIL %s stall got %b want %b", e.name, stall, e.st);
         end
         checks++;
         if (md_busy !== e.bz) begin
            errors++;
            $display("FAIL %s md_busy got %b want %b", e.name, md_busy, e.bz);
         end
         checks++;
         if (md_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s md_cnt got %0d want %0d", e.name, md_cnt, e.cnt);
         end
`ifdef STALL_STATS_EN
         if (e.chk_sc) begin
            checks++;
            if (stall_cycles !== e.sc) begin
               errors++;
               $display("FAIL %s stall_cycles got %0d want %0d",
                        e.name, stall_cycles, e.sc);
            end
         end
`endif
      end
   end

   // A mult/div must never reach E while the md unit is still busy.
   always @(negedge clk) begin
      if (reset === 1'b1 && md_busy === 1'b1 && is_muldiv(DE_IR)) begin
         errors++;
         $display("FAIL md_restart_in_busy DE_IR %h", DE_IR);
      end
   end

   initial begin
      reset = 1'b0;
      FD_IR = '0;
      DE_IR = '0;
      EM_IR = '0;
      @(posedge clk);
      #1;
      step("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd0);

      step("lw_addu",  1'b1, ADDU_R, LW1,   0,     1'b1, 1'b0, 8'd0);
      step("lw_sw_rt", 1'b1, SW1,    LW1,   0,     1'b0, 1'b0, 8'd0);
      step("lw_sw_rs", 1'b1, SW_RS1, LW1,   0,     1'b1, 1'b0, 8'd0);
      step("addu_beq", 1'b1, BEQ_A,  ADDU1, 0,     1'b1, 1'b0, 8'd0);
      step("em_addu",  1'b1, BEQ_A,  0,     ADDU1, 1'b0, 1'b0, 8'd0);
      step("em_lw_bq", 1'b1, BEQ_B,  0,     LW1,   1'b1, 1'b0, 8'd0);
      step("em_lw0",   1'b1, BEQ_B,  0,     LW0,   1'b0, 1'b0, 8'd0);
      step("em_lw_ad", 1'b1, ADDU_R, 0,     LW1,   1'b0, 1'b0, 8'd0);
      step("jal_jr",   1'b1, JR31,   JAL,   0,     1'b0, 1'b0, 8'd0);

      step("rst2", 1'b0, 0, 0, 0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd0);
      step("mult_st", 1'b1, MFHI, MULT, 0, 1'b1, 1'b0, 8'd0);
      for (int i = 5; i >= 1; i--)
         step("mult_bz", 1'b1, MFHI, 0, 0, 1'b1, 1'b1, 8'(i));
      step("mult_rel", 1'b1, MFHI, 0, 0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd6);

      step("mult_nomd", 1'b1, ADDU1, MULT, 0, 1'b0, 1'b0, 8'd0);
      for (int i = 5; i >= 1; i--)
         step("mult_nomd_bz", 1'b1, ADDU1, 0, 0, 1'b0, 1'b1, 8'(i));
      step("mult_nomd_idle", 1'b1, ADDU1, 0, 0, 1'b0, 1'b0, 8'd0);

      step("div_st", 1'b1, 0, DIV, 0, 1'b0, 1'b0, 8'd0);
      for (int i = 10; i >= 7; i--)
         step("div_bz", 1'b1, 0, 0, 0, 1'b0, 1'b1, 8'(i));
      FD_IR = '0;
      DE_IR = '0;
      push("div_cnt6", 1'b0, 1'b1, 8'd6, 1'b0, 32'd0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      FD_IR = MFLO;
      push("div_rst", 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;

      step("rst_data", 1'b0, ADDU_R, LW1, 0, 1'b1, 1'b0, 8'd0);
      step("rel_mflo", 1'b1, MFLO,   0,   0, 1'b0, 1'b0, 8'd0);

      for (int i = 0; i < 5 && q.size() > 0; i++)
         @(posedge clk);
      #1;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
